// File: rtl/mux_2x1_32bit.sv
// Registered 2-to-1 word mux for the MIPS datapath.
// REGISTERED=0 builds a purely combinational select.
module mux_2x1_32bit #(
  parameter int WIDTH      = 32,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inpA,
  input  logic [WIDTH-1:0] inpB,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] sel_word;

  assign sel_word = sel ? inpB : inpA;

  generate
    if (REGISTERED) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= '0;
        else        out <= sel_word;
      end
    end else begin : g_comb
      // clk and rst_n are intentionally ignored here
      logic unused;
      assign unused = clk ^ rst_n;
      assign out    = sel_word;
    end
  endgenerate

endmodule

// File: tb/tb_mux_2x1_32bit.sv
// Directed bench for mux_2x1_32bit.
// Covers registered and combinational builds.
module tb_mux_2x1_32bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] inp_a;
  logic [31:0] inp_b;
  logic        sel;
  logic [31:0] out;

  logic        c_clk;
  logic        c_rst_n;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic        c_sel;
  logic [31:0] c_out;

  int n_run;
  int n_fail;

  mux_2x1_32bit #(.WIDTH(32), .REGISTERED(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .inpA  (inp_a),
    .inpB  (inp_b),
    .sel   (sel),
    .out   (out)
  );

  mux_2x1_32bit #(.WIDTH(32), .REGISTERED(1'b0)) dut_c (
    .clk   (c_clk),
    .rst_n (c_rst_n),
    .inpA  (c_a),
    .inpB  (c_b),
    .sel   (c_sel),
    .out   (c_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    inp_a   = 32'd3;
    inp_b   = 32'd4;
    sel     = 1'b0;
    c_clk   = 1'b0;
    c_rst_n = 1'b1;
    c_a     = 32'd0;
    c_b     = 32'd0;
    c_sel   = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("rst_async", out, 32'd0);

    // held in reset across edges
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("rst_hold", out, 32'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release", out, 32'd0);
    after_edge();
    check("sel_a_first", out, 32'd3);
    after_edge();
    check("sel_a_stay", out, 32'd3);

    @(negedge clk);
    sel = 1'b1;
    #1 check("sel_b_wait", out, 32'd3);
    after_edge();
    check("sel_b_load", out, 32'd4);

    @(negedge clk);
    inp_a = 32'hFFFF_FFFF;
    after_edge();
    check("iso_inpa", out, 32'd4);

    @(negedge clk);
    #2 inp_b = 32'hDEAD_BEEF;
    #1 check("iso_midcyc", out, 32'd4);
    after_edge();
    check("lat_inpb", out, 32'hDEAD_BEEF);

    // async reset mid-cycle with out = 4
    @(negedge clk);
    inp_b = 32'd4;
    after_edge();
    check("pre_rst", out, 32'd4);
    #1 rst_n = 1'b0;
    #1 check("rst_mid", out, 32'd0);
    after_edge();
    check("rst_mid_hold", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full-width alternation
    inp_a = 32'hAAAA_AAAA;
    inp_b = 32'h5555_5555;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sel = i[0];
      after_edge();
      check("alt", out, i[0] ? 32'h5555_5555 : 32'hAAAA_AAAA);
    end

    // combinational build
    c_a   = 32'd3;
    c_b   = 32'd4;
    c_sel = 1'b0;
    #1 check("comb_a", c_out, 32'd3);
    c_sel = 1'b1;
    #1 check("comb_b", c_out, 32'd4);
    c_rst_n = 1'b0;
    #1 check("comb_rst", c_out, 32'd4);
    c_b = 32'h1234_5678;
    #1 check("comb_follow", c_out, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_2x1_32bit.md
# mux_2x1_32bit

Registered 2-to-1 word multiplexer for the MIPS datapath. Selects between two 32-bit operands (e.g. register-file data vs. sign-extended immediate, ALU result vs. memory data) and presents the chosen word on a clocked output register. Output updates on the rising clock edge and clears asynchronously on reset.

## Interface
- WIDTH, 32, data width of inpA, inpB and out.
- REGISTERED, 1, 1 = output registered on clk; 0 = purely combinational output (clk/rst_n unused).
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- inpA  input  WIDTH  data input selected when sel = 0.
- inpB  input  WIDTH  data input selected when sel = 1.
- sel  input  1  select: 0 → inpA, 1 → inpB.
- out  output  WIDTH  selected word.

## Operation
- Selection function: next = sel ? inpB : inpA, full-width bitwise, no arithmetic, no sign/zero modification.
- sel is treated as a strict 1-bit control; sel = X/Z is not a legal operating condition (simulation may propagate X).
- REGISTERED = 1:
  - out is a WIDTH-bit flop loaded with next on every rising clk edge while rst_n = 1.
  - No enable; register loads every cycle.
  - rst_n = 0 forces out to 0 immediately (asynchronous), independent of clk; held at 0 while rst_n low.
- REGISTERED = 0:
  - out = next continuously; reset has no effect; out follows inputs within the same delta.
- No internal state other than the output register; no handshake.

## Timing
- Reset value: out = 0 (all WIDTH bits).
- Latency (REGISTERED = 1): 1 clock — inputs sampled at rising edge N appear on out after edge N, stable until edge N+1.
- Inputs changing between edges do not affect out until the next rising edge.
- Inputs changing coincident with a rising edge: pre-edge values are sampled (standard flop setup semantics); bench must change stimulus away from edges.
- Reset deassertion (rst_n 0→1): asynchronous release; first load occurs at the first rising edge after release. Deassertion should be synchronous to clk externally; the block does not synchronize it.
- Reset asserted mid-operation: out clears immediately, regardless of sel/inputs/clock phase.
- Before first edge after power-up with no reset: out is X; system must reset before use.

## Test plan
- Reset: rst_n = 0 with inpA = 3, inpB = 4, sel = 0, clk toggling → out = 0 throughout; assert rst_n low mid-run when out = 4 → out drops to 0 without waiting for an edge.
- Select A: rst_n = 1, inpA = 3, inpB = 4, sel = 0 → out = 3 after the first rising edge, stays 3 across subsequent edges.
- Select B: then sel = 1 (changed between edges, inputs unchanged) → out stays 3 until next rising edge, then out = 4.
- Latency/isolation: with sel = 1, change inpA to 0xFFFFFFFF → out stays 4; change inpB to 0xDEADBEEF mid-cycle → out becomes 0xDEADBEEF only at next rising edge.
- Full-width: inpA = 0xAAAAAAAA, inpB = 0x55555555, toggle sel each cycle → out alternates 0xAAAAAAAA / 0x55555555 one cycle behind sel, every bit verified.
- Combinational build (REGISTERED = 0): inpA = 3, inpB = 4, sel 0→1 → out 3→4 with no clock dependence; rst_n = 0 does not change out.
